// File: rtl/mem_arbiter.sv
// Two-port word arbiter: merges instruction-fetch and data-memory requests onto
// one shared memory port, one atomic transaction at a time, alternating on ties.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
endpackage

module mem_arbiter
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  // instruction port
  input  logic       i_read,
  input  lc3b_word   i_address,
  output lc3b_word   i_rdata,
  output logic       i_resp,
  // data port
  input  logic       d_read,
  input  logic       d_write,
  input  lc3b_word   d_address,
  input  lc3b_word   d_wdata,
  input  logic [1:0] d_byte_enable,
  output lc3b_word   d_rdata,
  output logic       d_resp,
  // shared memory port
  output logic       mem_read,
  output logic       mem_write,
  output lc3b_word   mem_address,
  output lc3b_word   mem_wdata,
  output logic [1:0] mem_byte_enable,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_e;

  typedef struct packed {
    logic       read;
    logic       write;
    lc3b_word   address;
    lc3b_word   wdata;
    logic [1:0] byte_enable;
  } mem_req_t;

  state_e   state_q, state_d;
  grant_e   last_grant_q, last_grant_d;
  mem_req_t mreq;

  logic i_act, d_act;
  assign i_act = i_read;
  assign d_act = d_read | d_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // An active request dropping mid-serve is an abort: back to IDLE, no resp.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (i_act && d_act) begin
          if (last_grant_q == GNT_I) begin
            state_d      = SERVE_D;
            last_grant_d = GNT_D;
          end else begin
            state_d      = SERVE_I;
            last_grant_d = GNT_I;
          end
        end else if (d_act) begin
          state_d      = SERVE_D;
          last_grant_d = GNT_D;
        end else if (i_act) begin
          state_d      = SERVE_I;
          last_grant_d = GNT_I;
        end
      end
      SERVE_I: if (!i_act || mem_resp) state_d = IDLE;
      SERVE_D: if (!d_act || mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mreq    = '0;
    i_rdata = '0;
    i_resp  = 1'b0;
    d_rdata = '0;
    d_resp  = 1'b0;
    unique case (state_q)
      SERVE_I: begin
        mreq.read        = i_read;
        mreq.address     = i_address;
        mreq.byte_enable = 2'b11;
        i_rdata          = mem_rdata;
        i_resp           = i_act & mem_resp;
      end
      SERVE_D: begin
        // write takes priority if a requester raises both strobes
        mreq.write       = d_write;
        mreq.read        = d_read & ~d_write;
        mreq.address     = d_address;
        mreq.wdata       = d_wdata;
        mreq.byte_enable = d_byte_enable;
        d_rdata          = mem_rdata;
        d_resp           = d_act & mem_resp;
      end
      default: ;
    endcase
  end

  assign mem_read        = mreq.read;
  assign mem_write       = mreq.write;
  assign mem_address     = mreq.address;
  assign mem_wdata       = mreq.wdata;
  assign mem_byte_enable = mreq.byte_enable;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, lone read, tie, contention, byte write, abort.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read, d_read, d_write, mem_resp;
  logic [15:0] i_address, d_address, d_wdata, mem_rdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [1:0]  mem_byte_enable;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; mem_rdata = 0; d_byte_enable = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 0;
    i_read = 1; d_write = 1; i_address = 16'h1111; d_address = 16'h2222;
    step(); #1;
    total++; if (mem_read !== 1'b0)  $display("FAIL rst_mem_read got %0h want 0", mem_read);  else pass_cnt++;
    total++; if (mem_write !== 1'b0) $display("FAIL rst_mem_write got %0h want 0", mem_write); else pass_cnt++;
    total++; if (mem_address !== 16'h0) $display("FAIL rst_mem_address got %h want 0000", mem_address); else pass_cnt++;
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL rst_resp got %b want 00", {i_resp, d_resp}); else pass_cnt++;
    clear_inputs();
    step();
    rst_n = 1; #1;
    total++; if ({mem_read, mem_write, mem_byte_enable, mem_wdata} !== '0)
      $display("FAIL rst_release_outputs got %b%b%b %h want all 0", mem_read, mem_write, mem_byte_enable, mem_wdata); else pass_cnt++;
  endtask

  task automatic test_lone_read;
    int ipulses = 0;
    int dbad = 0;
    int abad = 0;
    do_reset();
    i_read = 1; i_address = 16'h1234; #1;
    total++; if (mem_read !== 1'b0) $display("FAIL lone_idle_mem_read got %0h want 0", mem_read); else pass_cnt++;
    step();
    total++; if (mem_read !== 1'b1) $display("FAIL lone_mem_read got %0h want 1", mem_read); else pass_cnt++;
    total++; if (mem_byte_enable !== 2'b11) $display("FAIL lone_byte_enable got %b want 11", mem_byte_enable); else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin mem_resp = 1; mem_rdata = 16'hBEEF; #1; end
      if (mem_address !== 16'h1234) abad++;
      if (d_resp !== 1'b0 || d_rdata !== 16'h0) dbad++;
      if (i_resp === 1'b1) begin
        ipulses++;
        total++; if (i_rdata !== 16'hBEEF) $display("FAIL lone_i_rdata got %h want beef", i_rdata); else pass_cnt++;
        total++; if (c != 3) $display("FAIL lone_resp_cycle got %0d want 3", c); else pass_cnt++;
      end
      step();
    end
    i_read = 0; mem_resp = 0; mem_rdata = 0; #1;
    total++; if (mem_read !== 1'b0 || i_resp !== 1'b0) $display("FAIL lone_after got rd=%0h resp=%0h want 0 0", mem_read, i_resp); else pass_cnt++;
    total++; if (ipulses != 1) $display("FAIL lone_i_pulses got %0d want 1", ipulses); else pass_cnt++;
    total++; if (abad != 0) $display("FAIL lone_address_hold got %0d bad want 0", abad); else pass_cnt++;
    total++; if (dbad != 0) $display("FAIL lone_d_quiet got %0d bad want 0", dbad); else pass_cnt++;
  endtask

  task automatic test_tie;
    do_reset();
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h2000;
    step();
    total++; if (mem_address !== 16'h2000 || mem_read !== 1'b1)
      $display("FAIL tie_first got addr=%h rd=%0h want 2000 1", mem_address, mem_read); else pass_cnt++;
    mem_resp = 1; mem_rdata = 16'h1111; #1;
    total++; if (d_resp !== 1'b1 || d_rdata !== 16'h1111 || i_resp !== 1'b0)
      $display("FAIL tie_d_resp got d=%0h %h i=%0h want 1 1111 0", d_resp, d_rdata, i_resp); else pass_cnt++;
    step();
    d_read = 0; mem_resp = 0; #1;
    total++; if (mem_read !== 1'b0 || i_resp !== 1'b0) $display("FAIL tie_idle got rd=%0h i=%0h want 0 0", mem_read, i_resp); else pass_cnt++;
    step();
    total++; if (mem_address !== 16'h0100 || mem_read !== 1'b1)
      $display("FAIL tie_second got addr=%h rd=%0h want 0100 1", mem_address, mem_read); else pass_cnt++;
    mem_resp = 1; mem_rdata = 16'h2222; #1;
    total++; if (i_resp !== 1'b1 || i_rdata !== 16'h2222 || d_resp !== 1'b0)
      $display("FAIL tie_i_resp got i=%0h %h d=%0h want 1 2222 0", i_resp, i_rdata, d_resp); else pass_cnt++;
    step();
    clear_inputs(); #1;
  endtask

  task automatic test_back_to_back;
    logic [7:0] order;
    logic [7:0] want = 8'b01010101; // bit t = 1 means D granted for transaction t
    int idle_bad = 0;
    do_reset();
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h2000;
    order = '0;
    for (int t = 0; t < 8; t++) begin
      #1;
      if (mem_read !== 1'b0 || mem_address !== 16'h0) idle_bad++;
      step();
      order[t] = (mem_address == 16'h2000);
      mem_resp = 1; #1;
      if (order[t] ? (d_resp !== 1'b1) : (i_resp !== 1'b1)) idle_bad++;
      step();
      mem_resp = 0;
    end
    total++; if (order !== want) $display("FAIL b2b_order got %b want %b", order, want); else pass_cnt++;
    total++; if (idle_bad != 0) $display("FAIL b2b_idle_resp got %0d bad want 0", idle_bad); else pass_cnt++;
    clear_inputs(); #1;
  endtask

  task automatic test_byte_write;
    do_reset();
    d_write = 1; d_address = 16'h3001; d_wdata = 16'h00A5; d_byte_enable = 2'b01;
    step();
    total++; if ({mem_write, mem_read} !== 2'b10) $display("FAIL bw_strobes got %b want 10", {mem_write, mem_read}); else pass_cnt++;
    total++; if (mem_wdata !== 16'h00A5) $display("FAIL bw_wdata got %h want 00a5", mem_wdata); else pass_cnt++;
    total++; if (mem_byte_enable !== 2'b01) $display("FAIL bw_be got %b want 01", mem_byte_enable); else pass_cnt++;
    total++; if (mem_address !== 16'h3001) $display("FAIL bw_addr got %h want 3001", mem_address); else pass_cnt++;
    d_read = 1; #1;
    total++; if ({mem_write, mem_read} !== 2'b10) $display("FAIL bw_rw_both got %b want 10", {mem_write, mem_read}); else pass_cnt++;
    mem_resp = 1; #1;
    total++; if (d_resp !== 1'b1) $display("FAIL bw_resp got %0h want 1", d_resp); else pass_cnt++;
    step();
    clear_inputs(); #1;
  endtask

  task automatic test_abort_stray;
    do_reset();
    i_read = 1; i_address = 16'h4000;
    step();
    total++; if (mem_read !== 1'b1) $display("FAIL ab_mem_read got %0h want 1", mem_read); else pass_cnt++;
    i_read = 0; #1;
    step();
    total++; if (mem_read !== 1'b0 || mem_address !== 16'h0) $display("FAIL ab_idle got rd=%0h addr=%h want 0 0000", mem_read, mem_address); else pass_cnt++;
    mem_resp = 1; mem_rdata = 16'h5555; #1;
    total++; if ({i_resp, d_resp} !== 2'b00) $display("FAIL ab_stray_resp got %b want 00", {i_resp, d_resp}); else pass_cnt++;
    total++; if ({i_rdata, d_rdata} !== 32'h0) $display("FAIL ab_stray_rdata got %h want 0", {i_rdata, d_rdata}); else pass_cnt++;
    step();
    mem_resp = 0; #1;
    total++; if (mem_read !== 1'b0) $display("FAIL ab_still_idle got %0h want 0", mem_read); else pass_cnt++;
    d_read = 1; d_address = 16'h6000;
    step();
    total++; if (mem_address !== 16'h6000 || mem_read !== 1'b1)
      $display("FAIL ab_next_grant got addr=%h rd=%0h want 6000 1", mem_address, mem_read); else pass_cnt++;
    clear_inputs(); step();
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    d_write = 1; d_address = 16'h5000; d_wdata = 16'h1234; d_byte_enable = 2'b11;
    step();
    total++; if (mem_write !== 1'b1) $display("FAIL rm_inflight got %0h want 1", mem_write); else pass_cnt++;
    #2; rst_n = 0; #1;
    total++; if (mem_write !== 1'b0 || mem_address !== 16'h0)
      $display("FAIL rm_async_drop got wr=%0h addr=%h want 0 0000", mem_write, mem_address); else pass_cnt++;
    step();
    d_write = 0; i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h2000;
    step();
    rst_n = 1; #1;
    total++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL rm_release_idle got %b want 00", {mem_read, mem_write}); else pass_cnt++;
    step();
    total++; if (mem_address !== 16'h2000) $display("FAIL rm_tie_d_first got %h want 2000", mem_address); else pass_cnt++;
    clear_inputs(); step();
  endtask

  initial begin
    test_reset();
    test_lone_read();
    test_tie();
    test_back_to_back();
    test_byte_write();
    test_abort_stray();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sitting directly downstream of the pipeline's instruction-fetch memory controller and the MEM-stage data memory controller. It merges their independent word requests onto the single shared memory port. Each transaction is granted atomically and routed back to its requester. On contention it alternates between the two ports.

## Interface
- No parameters; widths fixed by `lc3b_types` (`lc3b_word` = 16 bits).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `i_read` in 1: instruction-port read request; held high until `i_resp`.
- `i_address` in 16: instruction-port word address.
- `i_rdata` out 16: read data to instruction port.
- `i_resp` out 1: one-cycle completion pulse to instruction port.
- `d_read` in 1: data-port read request; held until `d_resp`.
- `d_write` in 1: data-port write request; held until `d_resp`.
- `d_address` in 16: data-port address.
- `d_wdata` in 16: data-port write data.
- `d_byte_enable` in 2: data-port byte enables (bit0 low byte, bit1 high byte).
- `d_rdata` out 16: read data to data port.
- `d_resp` out 1: one-cycle completion pulse to data port.
- `mem_read` out 1: shared memory read strobe.
- `mem_write` out 1: shared memory write strobe.
- `mem_address` out 16: shared memory address.
- `mem_wdata` out 16: shared memory write data.
- `mem_byte_enable` out 2: shared memory byte enables.
- `mem_rdata` in 16: shared memory read data.
- `mem_resp` in 1: shared memory completion.

## Operation
- States: IDLE, SERVE_I, SERVE_D. One extra flop `last_grant` (I or D).
- IDLE, one requester active: go to that requester's SERVE state.
  - Instruction port is active when `i_read` is high.
  - Data port is active when `d_read | d_write` is high.
- IDLE, both active: grant the port opposite `last_grant`.
- IDLE, neither active: stay in IDLE.
- On entering SERVE_x: `last_grant <= x`.
- SERVE_x, granted request still high and `mem_resp`=1: pulse `x_resp` this cycle, then go to IDLE.
- SERVE_x, granted request drops before `mem_resp` (abort): go to IDLE; no resp pulse.
- SERVE_x never switches directly to the other port. IDLE is always visited between grants, which gives requesters the cycle after resp to drop their request.
- Memory-side outputs are combinational from state and the granted port's inputs.
  - SERVE_I: `mem_read=i_read`, `mem_write=0`, `mem_address=i_address`, `mem_wdata=0`, `mem_byte_enable=2'b11`.
  - SERVE_D: `mem_write=d_write`, `mem_read=d_read & ~d_write` (write wins if both set), `mem_address=d_address`, `mem_wdata=d_wdata`, `mem_byte_enable=d_byte_enable`.
  - IDLE: all `mem_*` outputs 0.
- Response outputs:
  - `i_resp = (state==SERVE_I) & i_read & mem_resp`.
  - `d_resp = (state==SERVE_D) & (d_read|d_write) & mem_resp`.
- `i_rdata` = `mem_rdata` in SERVE_I, else 0. `d_rdata` = `mem_rdata` in SERVE_D, else 0.
- `mem_resp` arriving in IDLE is ignored: no resp pulse, no state change.
- Non-granted requester sees only zeros on its rdata and resp; it simply waits.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `last_grant`=I.
  - Every output is 0 while reset is held and on the first cycle after release.
  - Reset mid-transaction drops `mem_read`/`mem_write` immediately, without waiting for a clock edge.
- Request first high in IDLE at cycle N: `mem_*` strobes driven from cycle N+1.
- `mem_resp` high in cycle M (M ≥ N+1): `x_resp` and valid `x_rdata` in cycle M only; state is IDLE at M+1.
- Minimum occupancy: 2 cycles per transaction (IDLE + SERVE).
- Under continuous contention, grants alternate D, I, D, I …; D is first after reset.
- Granted requests cannot starve: a pending request is served after at most one other transaction.

## Test plan
- Reset mid-SERVE_D (`d_write`=1 in flight), pull `rst_n` low between edges -> `mem_write` falls to 0 the same cycle; after release, state is IDLE and a fresh tie grants D first.
- Lone instruction read: `i_read`=1, `i_address`=0x1234; memory returns 0xBEEF with `mem_resp` three cycles after `mem_read` rises ->
  - `mem_address`=0x1234 throughout;
  - `i_resp` is a single pulse with `i_rdata`=0xBEEF;
  - `d_resp`=0 and `d_rdata`=0 throughout.
- Tie after reset: `i_read`=1 at 0x0100 and `d_read`=1 at 0x2000 in the same cycle ->
  - D transaction (0x2000) completes first;
  - one IDLE cycle follows;
  - I transaction (0x0100) completes; I held its request and never saw a resp early.
- Sustained contention: both ports re-request in the cycle after each resp for 8 transactions -> grant order D,I,D,I,D,I,D,I with exactly one IDLE cycle between each.
- Byte write: `d_write`=1, `d_address`=0x3001, `d_wdata`=0x00A5, `d_byte_enable`=2'b01 ->
  - `mem_write`=1, `mem_read`=0, `mem_wdata`=0x00A5, `mem_byte_enable`=2'b01;
  - with `d_read`=1 also set, `mem_read` stays 0.
- Abort plus stray response: `i_read` dropped in SERVE_I before `mem_resp` -> IDLE at the next edge with `mem_read`=0; a later `mem_resp` pulse in IDLE produces no `i_resp`/`d_resp` and no state change.
